// File: rtl/instr_sequencer.sv
// Five-state instruction sequencer for the register-file / ALU / write-back datapath.
// Accepts one MIPS word, decodes R-type ALU ops and LUI, and steps READ -> EXEC -> WB.
module instr_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_in,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [4:0]  rr1,
    output logic [4:0]  rr2,
    output logic [4:0]  wr,
    output logic        we,
    output logic [3:0]  alu_op,
    output logic [4:0]  shift_count,
    output logic        wd_sel,
    output logic [31:0] imm_out,
    output logic        done,
    output logic        illegal,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_READ   = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] instr_q;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic        dec_legal;
    logic [3:0]  dec_op;
    logic [4:0]  dec_rr1, dec_rr2, dec_wr, dec_sh;
    logic        dec_sel;
    logic [31:0] dec_imm;

    assign opcode = instr_q[31:26];
    assign rs     = instr_q[25:21];
    assign rt     = instr_q[20:16];
    assign rd     = instr_q[15:11];
    assign shamt  = instr_q[10:6];
    assign funct  = instr_q[5:0];

    assign instr_ready = (state == S_IDLE);

    always_comb begin
        dec_legal = 1'b0;
        dec_op    = 4'b0010;
        dec_rr1   = rs;
        dec_rr2   = rt;
        dec_wr    = rd;
        dec_sh    = shamt;
        dec_sel   = 1'b1;
        dec_imm   = 32'h0000_0000;
        if (opcode == 6'h00) begin
            dec_legal = 1'b1;
            case (funct)
                6'h20: dec_op = 4'b0010;
                6'h22: dec_op = 4'b0110;
                6'h24: dec_op = 4'b0000;
                6'h25: dec_op = 4'b0001;
                6'h27: dec_op = 4'b1100;
                6'h2A: dec_op = 4'b0111;
                6'h00: dec_op = 4'b1110;
                6'h02: dec_op = 4'b1101;
                6'h03: begin
                    // sra shifts the A operand, so both read ports fetch rt
                    dec_op  = 4'b1111;
                    dec_rr1 = rt;
                end
                default: dec_legal = 1'b0;
            endcase
        end else if (opcode == 6'h0F) begin
            dec_legal = 1'b1;
            dec_wr    = rt;
            dec_sh    = 5'd0;
            dec_sel   = 1'b0;
            dec_imm   = {instr_q[15:0], 16'h0000};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            instr_q     <= 32'h0000_0000;
            rr1         <= 5'd0;
            rr2         <= 5'd0;
            wr          <= 5'd0;
            we          <= 1'b0;
            alu_op      <= 4'b0000;
            shift_count <= 5'd0;
            wd_sel      <= 1'b0;
            imm_out     <= 32'h0000_0000;
            done        <= 1'b0;
            illegal     <= 1'b0;
            retired     <= 16'd0;
        end else begin
            we      <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr_in;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (dec_legal) begin
                        rr1         <= dec_rr1;
                        rr2         <= dec_rr2;
                        wr          <= dec_wr;
                        alu_op      <= dec_op;
                        shift_count <= dec_sh;
                        wd_sel      <= dec_sel;
                        imm_out     <= dec_imm;
                        state       <= S_READ;
                    end else begin
                        illegal <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                S_READ: state <= S_EXEC;
                S_EXEC: begin
                    // writes to $0 retire normally but never strobe the register file
                    we    <= (wr != 5'd0);
                    done  <= 1'b1;
                    state <= S_WB;
                end
                S_WB: begin
                    retired <= retired + 16'd1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a behavioural register file and ALU close the loop, and an
// architectural model of the instruction set predicts outputs, timing and register contents.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_in = 32'h0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [4:0]  rr1, rr2, wr;
    logic        we;
    logic [3:0]  alu_op;
    logic [4:0]  shift_count;
    logic        wd_sel;
    logic [31:0] imm_out;
    logic        done;
    logic        illegal;
    logic [15:0] retired;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .rr1         (rr1),
        .rr2         (rr2),
        .wr          (wr),
        .we          (we),
        .alu_op      (alu_op),
        .shift_count (shift_count),
        .wd_sel      (wd_sel),
        .imm_out     (imm_out),
        .done        (done),
        .illegal     (illegal),
        .retired     (retired)
    );

    // Datapath stand-in: register file (negedge read, posedge write), ALU and write-back mux.
    logic [31:0] rf [32];
    logic [31:0] out1 = 32'h0, out2 = 32'h0, alu_res, wd;
    logic        pl_en = 1'b0;
    logic [4:0]  pl_addr = 5'd0;
    logic [31:0] pl_data = 32'h0;

    always @(negedge clk) begin
        out1 <= rf[rr1];
        out2 <= rf[rr2];
    end

    always_comb begin
        alu_res = 32'h0;
        case (alu_op)
            4'b0010: alu_res = out1 + out2;
            4'b0110: alu_res = out1 - out2;
            4'b0000: alu_res = out1 & out2;
            4'b0001: alu_res = out1 | out2;
            4'b1100: alu_res = ~(out1 | out2);
            4'b0111: alu_res = {31'h0, ($signed(out1) < $signed(out2))};
            4'b1110: alu_res = out2 << shift_count;
            4'b1101: alu_res = out2 >> shift_count;
            4'b1111: alu_res = $signed(out1) >>> shift_count;
            default: alu_res = 32'h0;
        endcase
    end

    assign wd = wd_sel ? alu_res : imm_out;

    always @(posedge clk) begin
        if (pl_en) rf[pl_addr] <= pl_data;
        else if (we) rf[wr] <= wd;
    end

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] model_rf [32];
    logic [3:0]  obs_ctl [1:5];
    logic [56:0] obs_fld [1:5];
    logic [15:0] obs_ret [1:5];
    logic [15:0] ret0;

    // Architectural reference: field layout {rr1,rr2,wr,op,shamt,sel,imm}, plus a don't-care mask.
    function automatic void model(input logic [31:0] ins, output logic [56:0] e_fld,
                                  output logic [56:0] e_mask, output logic [31:0] e_res);
        logic [4:0]  rs, rt, rd, sh, r1;
        logic [31:0] a, b;
        logic [3:0]  op;
        rs = ins[25:21];
        rt = ins[20:16];
        rd = ins[15:11];
        sh = ins[10:6];
        a  = model_rf[rs];
        b  = model_rf[rt];
        r1 = rs;
        op = 4'b0010;
        e_res = 32'h0;
        if (ins[31:26] == 6'h0F) begin
            e_res  = {ins[15:0], 16'h0000};
            e_fld  = {5'd0, 5'd0, rt, 4'b0010, 5'd0, 1'b0, e_res};
            e_mask = {5'h0, 5'h0, 5'h1F, 4'hF, 5'h0, 1'b1, 32'hFFFF_FFFF};
        end else begin
            case (ins[5:0])
                6'h20: begin op = 4'b0010; e_res = a + b; end
                6'h22: begin op = 4'b0110; e_res = a - b; end
                6'h24: begin op = 4'b0000; e_res = a & b; end
                6'h25: begin op = 4'b0001; e_res = a | b; end
                6'h27: begin op = 4'b1100; e_res = ~(a | b); end
                6'h2A: begin op = 4'b0111; e_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                6'h00: begin op = 4'b1110; e_res = b << sh; end
                6'h02: begin op = 4'b1101; e_res = b >> sh; end
                default: begin op = 4'b1111; r1 = rt; e_res = $signed(b) >>> sh; end
            endcase
            e_fld  = {r1, rt, rd, op, sh, 1'b1, 32'h0};
            e_mask = {25'h1FF_FFFF, 32'h0};
        end
    endfunction

    task automatic preload(input logic [4:0] addr, input logic [31:0] data);
        pl_en = 1'b1;
        pl_addr = addr;
        pl_data = data;
        model_rf[addr] = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; leaves off at the negedge of cycle ncyc.
    task automatic exec_instr(input logic [31:0] ins, input int ncyc);
        instr_in = ins;
        instr_valid = 1'b1;
        ret0 = retired;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr_in = $urandom;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            obs_ctl[c] = {we, done, illegal, instr_ready};
            obs_fld[c] = {rr1, rr2, wr, alu_op, shift_count, wd_sel, imm_out};
            obs_ret[c] = retired;
        end
    endtask

    task automatic test_instr(input logic [31:0] ins);
        logic [56:0] e_fld, e_mask;
        logic [31:0] e_res;
        logic [3:0]  e_ctl;
        logic [4:0]  e_wr;
        int          bad;
        model(ins, e_fld, e_mask, e_res);
        e_wr = e_fld[46:42];
        exec_instr(ins, 5);
        for (int c = 1; c <= 5; c++) begin
            e_ctl = {(c == 4) && (e_wr != 5'd0), (c == 4), 1'b0, (c == 5)};
            tests_run++;
            if (obs_ctl[c] !== e_ctl) begin
                tests_failed++;
                $display("FAIL ctl instr=%h cycle %0d: we/done/illegal/ready got %b expected %b",
                         ins, c, obs_ctl[c], e_ctl);
            end
        end
        for (int c = 2; c <= 4; c++) begin
            tests_run++;
            if ((obs_fld[c] & e_mask) !== (e_fld & e_mask)) begin
                tests_failed++;
                $display("FAIL fields instr=%h cycle %0d: got %h expected %h (mask %h)",
                         ins, c, obs_fld[c], e_fld, e_mask);
            end
        end
        tests_run++;
        if (obs_ret[4] !== ret0 || obs_ret[5] !== ret0 + 16'd1) begin
            tests_failed++;
            $display("FAIL retired instr=%h: got %h/%h expected %h/%h",
                     ins, obs_ret[4], obs_ret[5], ret0, ret0 + 16'd1);
        end
        if (e_wr != 5'd0) model_rf[e_wr] = e_res;
        bad = 0;
        for (int r = 0; r < 32; r++) if (rf[r] !== model_rf[r]) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL regfile instr=%h: %0d regs differ, reg%0d got %h expected %h",
                     ins, bad, e_wr, rf[e_wr], model_rf[e_wr]);
        end
    endtask

    task automatic test_illegal_one(input logic [31:0] ins);
        int bad;
        exec_instr(ins, 2);
        tests_run++;
        if (obs_ctl[1] !== 4'b0000 || obs_ctl[2] !== 4'b0011) begin
            tests_failed++;
            $display("FAIL illegal_ctl instr=%h: cycles 1/2 got %b/%b expected 0000/0011",
                     ins, obs_ctl[1], obs_ctl[2]);
        end
        tests_run++;
        if (obs_ret[2] !== ret0) begin
            tests_failed++;
            $display("FAIL illegal_retired instr=%h: got %h expected %h", ins, obs_ret[2], ret0);
        end
        bad = 0;
        for (int r = 0; r < 32; r++) if (rf[r] !== model_rf[r]) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL illegal_regfile instr=%h: %0d regs differ", ins, bad);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests_run++;
        if ({we, done, illegal, instr_ready} !== 4'b0001 || retired !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_ctl: we/done/illegal/ready=%b retired=%h expected 0001 0000",
                     {we, done, illegal, instr_ready}, retired);
        end
        tests_run++;
        if ({rr1, rr2, wr, alu_op, shift_count, wd_sel, imm_out} !== 57'h0) begin
            tests_failed++;
            $display("FAIL reset_fields: got %h expected 0",
                     {rr1, rr2, wr, alu_op, shift_count, wd_sel, imm_out});
        end
        for (int r = 0; r < 32; r++) preload(5'(r), 32'(r));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({we, done, illegal, instr_ready} !== 4'b0001 || retired !== 16'd0) begin
            tests_failed++;
            $display("FAIL idle_hold: we/done/illegal/ready=%b retired=%h expected 0001 0000",
                     {we, done, illegal, instr_ready}, retired);
        end
    endtask

    task automatic test_directed;
        test_instr(32'h0022_1820);
        preload(5'd5, 32'hFFFF_FFF8);
        test_instr(32'h0005_2083);
        tests_run++;
        if (rf[4] !== 32'hFFFF_FFFE) begin
            tests_failed++;
            $display("FAIL sra_result: reg4 got %h expected fffffffe", rf[4]);
        end
        test_instr(32'h3C07_1234);
        tests_run++;
        if (rf[7] !== 32'h1234_0000) begin
            tests_failed++;
            $display("FAIL lui_result: reg7 got %h expected 12340000", rf[7]);
        end
    endtask

    task automatic test_illegal;
        test_illegal_one(32'h0022_183F);
        test_instr(32'h0022_0020);
    endtask

    task automatic test_back_to_back;
        logic [5:0] legal_f [9];
        logic [5:0] bad_f [8];
        logic [31:0] ins;
        logic [5:0]  op;
        legal_f = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03};
        bad_f   = '{6'h01, 6'h08, 6'h21, 6'h23, 6'h26, 6'h2B, 6'h3F, 6'h18};
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    op = 6'($urandom_range(1, 63));
                    if (op == 6'h0F) op = 6'h10;
                    ins = {op, 26'($urandom)};
                end else begin
                    ins = {6'h00, 20'($urandom), bad_f[$urandom_range(0, 7)]};
                end
                test_illegal_one(ins);
            end else if ($urandom_range(0, 9) == 0) begin
                ins = {6'h0F, 5'($urandom), 5'($urandom), 16'($urandom)};
                test_instr(ins);
            end else begin
                ins = {6'h00, 20'($urandom), legal_f[$urandom_range(0, 8)]};
                test_instr(ins);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic saw;
        saw = 1'b0;
        preload(5'd3, 32'hDEAD_BEEF);
        instr_in = 32'h0022_1820;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        repeat (3) begin @(negedge clk); saw = saw | we | done | illegal; end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({we, done, illegal, instr_ready} !== 4'b0001 || retired !== 16'd0) begin
            tests_failed++;
            $display("FAIL async_reset: we/done/illegal/ready=%b retired=%h expected 0001 0000",
                     {we, done, illegal, instr_ready}, retired);
        end
        repeat (3) begin @(negedge clk); saw = saw | we | done | illegal; end
        rst_n = 1'b1;
        repeat (4) begin @(negedge clk); saw = saw | we | done | illegal; end
        tests_run++;
        if (saw !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_drop: we/done/illegal seen got %b expected 0", saw);
        end
        tests_run++;
        if (rf[3] !== 32'hDEAD_BEEF || retired !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_state: reg3 got %h expected deadbeef, retired got %h expected 0",
                     rf[3], retired);
        end
        test_instr(32'h0022_1820);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer: the initiator for the register-file / ALU / write-back-mux datapath. It accepts one 32-bit MIPS instruction at a time over a valid/ready handshake and decodes it. It then drives the register-file read and write addresses, write enable, ALU op code, shift count and write-back mux select through a fixed five-state sequence. It retires R-type ALU instructions and LUI; everything else is flagged illegal.

## Interface
- No parameters.
- clk  in  1  single clock; the register file reads on negedge and writes on posedge of this same clock.
- rst_n  in  1  reset, asynchronous and active-low.
- instr_in  in  32  instruction word, sampled on accept.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept; high iff state is IDLE (high during reset).
- rr1, rr2  out  5  register-file read addresses.
- wr  out  5  register-file write address.
- we  out  1  register-file write enable.
- alu_op  out  4  ALU op code: 0010 add, 0110 sub, 0000 and, 0001 or, 1100 nor, 0111 slt, 1110 sll, 1101 srl, 1111 sra.
- shift_count  out  5  ALU shift amount.
- wd_sel  out  1  write-back mux select: 0 = imm_out, 1 = ALU result.
- imm_out  out  32  immediate write data.
- done  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  one-cycle pulse when an instruction is rejected.
- retired  out  16  count of retired instructions.

## Operation
- States: IDLE -> DECODE -> READ -> EXEC -> WB -> IDLE.
  - Accept happens at the IDLE posedge where instr_valid && instr_ready; instr_in is latched there.
  - An illegal instruction goes DECODE -> IDLE.
- Decode, opcode = instr[31:26]:
  - opcode 0 (R-type), funct = instr[5:0]:
    - add 0x20, sub 0x22, and 0x24, or 0x25, nor 0x27, slt 0x2A: rr1 = rs[25:21], rr2 = rt[20:16].
    - sll 0x00, srl 0x02: rr1 = rs[25:21], rr2 = rt[20:16]; the ALU shifts its B operand.
    - sra 0x03: rr1 = rr2 = rt; the ALU shifts its A operand.
    - All R-type: wr = rd[15:11], shift_count = shamt[10:6], wd_sel = 1.
  - opcode 0x0F (LUI): wr = rt, imm_out = {instr[15:0], 16'h0000}, wd_sel = 0, alu_op = 0010; rr1 and rr2 are don't-care.
  - Any other opcode, or any other funct under opcode 0: illegal.
- All address, op and select outputs are registered at the DECODE posedge and held unchanged through WB.
- we = 1 only during WB, and only if wr != 0. A write to $0 is suppressed but still retires (done pulses, retired increments).
- done pulses during WB. retired increments at the end of WB, 16-bit, wrapping 0xFFFF -> 0x0000.
- illegal pulses during the cycle after DECODE (the return to IDLE). No we, no done, retired unchanged.
- instr_valid is ignored outside IDLE.

## Timing
- Reset (asynchronous, immediate): state = IDLE, instr_ready = 1, we = 0, done = 0, illegal = 0, retired = 0. rr1, rr2, wr, alu_op, shift_count, wd_sel and imm_out all reset to 0.
- Cycle numbering: accept edge = cycle 0.
  - DECODE is cycle 1; outputs become valid at the end of cycle 1.
  - READ is cycle 2; the register file updates Out1/Out2 at the cycle-2 negedge.
  - EXEC is cycle 3; the ALU result settles.
  - WB is cycle 4: we = 1, done = 1; the write commits at the posedge ending cycle 4.
  - IDLE again in cycle 5.
- Throughput: one instruction per 5 cycles. Back-to-back instructions have no read-after-write hazard, because the write lands before the next READ.
- Illegal instruction: illegal = 1 in cycle 2, instr_ready = 1 in cycle 2.
- Reset mid-instruction: the instruction is dropped; we drops asynchronously, and neither done nor illegal pulses.

## Test plan
- Reset: hold rst_n = 0 -> instr_ready = 1, we = 0, retired = 0, alu_op = 0000. Release, and with instr_valid = 0 -> stays in IDLE.
- add $3,$1,$2 (0x00221820), registers initialised to their index:
  - Expected outputs: rr1 = 1, rr2 = 2, wr = 3, alu_op = 0010, wd_sel = 1.
  - Expected timing: we high for exactly cycle 4, done pulses in cycle 4, retired = 1, register 3 = 3.
- sra $4,$5,2 (0x00052083), register 5 preloaded with -8 -> rr1 = rr2 = 5, alu_op = 1111, shift_count = 2, register 4 = -2.
- lui $7,0x1234 (0x3C071234) -> wd_sel = 0, imm_out = 0x12340000, wr = 7, register 7 = 0x12340000.
- Illegal funct 0x0022183F -> illegal in cycle 2, we never high, retired unchanged, next instruction accepted in cycle 2. Then add $0,$1,$2 (0x00220020) -> we stays 0, done pulses, retired increments, register 0 unchanged.
- Assert rst_n = 0 during EXEC of add $3,$1,$2 -> we never asserts, register 3 keeps its prior value, retired = 0 after reset.
